// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word widths, bubble
// encoding, reset level and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int          ADDR_LEN     = 32;
  localparam int          INST_LEN     = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        RESET_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_BUSY    = 2'd1,
    FS_DISCARD = 2'd2,
    FS_VALID   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup port plus a
// single-cycle fill port. Only the valid bits are cleared by reset.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int INST_W = INST_LEN,
  parameter int LINES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [INST_W-1:0] lk_data,
  input  logic              fill_we,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [INST_W-1:0] fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic             unused_lsbs;

  assign lk_idx      = lk_addr[IDX_W+1:2];
  assign fill_idx    = fill_addr[IDX_W+1:2];
  assign unused_lsbs = ^{lk_addr[1:0], fill_addr[1:0]};

  assign lk_hit  = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_addr[ADDR_W-1:IDX_W+2]);
  assign lk_data = data_mem[lk_idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_we) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) valid_q <= '0;
    else                     valid_q <= valid_d;
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
  // make stale contents unreachable, and leaving them out keeps the arrays RAM-mappable.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_addr[ADDR_W-1:IDX_W+2];
      data_mem[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads and presents if_pc/if_inst.
// Optional direct-mapped icache enabled by defining INST_FETCH_ICACHE_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W       = ADDR_LEN,
  parameter int INST_W       = INST_LEN,
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [INST_W-1:0] mem_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              stall_req
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              stall_req_q, stall_req_d;

  logic ready;
  logic issue;
  logic fill_we;
  logic unused_stall;

  assign ready        = mem_ready & mem_req_q;  // a response with no request outstanding is noise
  assign unused_stall = ^stall[5:2];

`ifdef INST_FETCH_ICACHE_EN
  logic              lk_hit;
  logic [INST_W-1:0] lk_data;

  inst_fetch_icache #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .LINES  (ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .lk_addr   (pc_q),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .fill_we   (fill_we),
    .fill_addr (mem_addr_q),
    .fill_data (mem_data)
  );
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    fill_we    = 1'b0;
    issue      = 1'b0;

    unique case (state_q)
      FS_IDLE:  issue = 1'b1;
      FS_BUSY: begin
        if (ready) begin
          if_inst_d = mem_data;
          if_pc_d   = mem_addr_q;
          if (!stall[0]) pc_d = pc_q + ADDR_W'(4);
          mem_req_d = 1'b0;
          fill_we   = 1'b1;
          state_d   = FS_VALID;
        end
      end
      FS_VALID: issue = !stall[1];
      FS_DISCARD: begin
        if (ready) begin
          mem_req_d = 1'b0;
          state_d   = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (issue) begin
`ifdef INST_FETCH_ICACHE_EN
      if (lk_hit) begin
        if_inst_d = lk_data;
        if_pc_d   = pc_q;
        if (!stall[0]) pc_d = pc_q + ADDR_W'(4);
        state_d   = FS_VALID;
      end else
`endif
      begin
        mem_req_d  = 1'b1;
        mem_addr_d = pc_q;
        state_d    = FS_BUSY;
      end
    end

    // Redirect wins over everything above: drop any new request or fill, keep the
    // address stable for a fetch that is still outstanding.
    if (jump_en) begin
      pc_d       = jump_addr;
      if_inst_d  = INST_W'(ZERO_WORD);
      if_pc_d    = if_pc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      fill_we    = 1'b0;
      unique case (state_q)
        FS_BUSY: begin
          if (ready) begin
            mem_req_d = 1'b0;
            state_d   = FS_IDLE;
          end else begin
            state_d   = FS_DISCARD;
          end
        end
        FS_DISCARD: state_d = FS_DISCARD;
        default:    state_d = FS_IDLE;
      endcase
    end

    stall_req_d = (state_d != FS_VALID);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state_q     <= FS_IDLE;
      pc_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign stall_req = stall_req_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; the icache scenario runs only when
// INST_FETCH_ICACHE_EN is defined.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stall_req;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] D0 = 32'h0000_0093;
  localparam logic [31:0] D1 = 32'h0010_0113;
  localparam logic [31:0] D2 = 32'h0020_0193;
  localparam logic [31:0] D3 = 32'h0030_0213;
  localparam logic [31:0] D4 = 32'h0040_0293;
  localparam logic [31:0] D5 = 32'h0050_0313;
  localparam logic [31:0] D6 = 32'h0060_0393;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .stall_req (stall_req)
  );

  // Outputs are sampled and inputs changed 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; jump_en = 1'b0; jump_addr = '0; mem_ready = 1'b0; mem_data = '0;
    tick(); tick(); tick();
    n_total++; if (if_pc !== 32'h0)   $display("FAIL rst_if_pc: got %h want %h", if_pc, 32'h0);       else n_pass++;
    n_total++; if (if_inst !== 32'h0) $display("FAIL rst_if_inst: got %h want %h", if_inst, 32'h0);   else n_pass++;
    n_total++; if (mem_req !== 1'b0)  $display("FAIL rst_mem_req: got %b want 0", mem_req);           else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want %h", mem_addr, 32'h0); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL rst_stall_req: got %b want 0", stall_req);      else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (mem_req !== 1'b1)   $display("FAIL first_req: got %b want 1", mem_req);            else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL first_addr: got %h want %h", mem_addr, 32'h0);  else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      n_total++; if (stall_req !== 1'b1) $display("FAIL busy_stall_req c%0d: got %b want 1", c, stall_req); else n_pass++;
      if (c == 4) begin mem_ready = 1'b1; mem_data = D0; end
      tick();
    end
    mem_ready = 1'b0;
    n_total++; if (if_pc !== 32'h0)   $display("FAIL lat3_if_pc: got %h want %h", if_pc, 32'h0);     else n_pass++;
    n_total++; if (if_inst !== D0)    $display("FAIL lat3_if_inst: got %h want %h", if_inst, D0);    else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL lat3_stall_req: got %b want 0", stall_req);    else n_pass++;
    n_total++; if (mem_req !== 1'b0)  $display("FAIL lat3_req_drop: got %b want 0", mem_req);        else n_pass++;
  endtask

  // Entered in VALID(0x0) with stall=0; responses arrive in the first BUSY cycle.
  task automatic test_back_to_back();
    logic [31:0] exp_pc   [2];
    logic [31:0] exp_inst [2];
    exp_pc[0] = 32'h4; exp_inst[0] = D1;
    exp_pc[1] = 32'h8; exp_inst[1] = D2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (mem_req !== 1'b1)       $display("FAIL b2b_req%0d: got %b want 1", i, mem_req);                 else n_pass++;
      n_total++; if (mem_addr !== exp_pc[i]) $display("FAIL b2b_addr%0d: got %h want %h", i, mem_addr, exp_pc[i]);   else n_pass++;
      mem_ready = 1'b1; mem_data = exp_inst[i];
      tick();
      mem_ready = 1'b0;
      n_total++; if (if_pc !== exp_pc[i])     $display("FAIL b2b_pc%0d: got %h want %h", i, if_pc, exp_pc[i]);       else n_pass++;
      n_total++; if (if_inst !== exp_inst[i]) $display("FAIL b2b_inst%0d: got %h want %h", i, if_inst, exp_inst[i]); else n_pass++;
      n_total++; if (stall_req !== 1'b0)      $display("FAIL b2b_stall_req%0d: got %b want 0", i, stall_req);        else n_pass++;
    end
  endtask

  // Entered in VALID(0x8); then checks that stall[0] freezes the PC across a fetch.
  task automatic test_stall_hold();
    stall = 6'b000010;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if (if_pc !== 32'h8)  $display("FAIL hold_pc c%0d: got %h want %h", c, if_pc, 32'h8);    else n_pass++;
      n_total++; if (if_inst !== D2)   $display("FAIL hold_inst c%0d: got %h want %h", c, if_inst, D2);   else n_pass++;
      n_total++; if (mem_req !== 1'b0) $display("FAIL hold_req c%0d: got %b want 0", c, mem_req);        else n_pass++;
    end
    stall = '0;
    tick();
    n_total++; if (mem_req !== 1'b1)   $display("FAIL release_req: got %b want 1", mem_req);              else n_pass++;
    n_total++; if (mem_addr !== 32'hC) $display("FAIL release_addr: got %h want %h", mem_addr, 32'hC);   else n_pass++;
    stall = 6'b000001; mem_ready = 1'b1; mem_data = D3;
    tick();
    stall = '0; mem_ready = 1'b0;
    n_total++; if (if_pc !== 32'hC) $display("FAIL pcfreeze_if_pc: got %h want %h", if_pc, 32'hC); else n_pass++;
    tick();
`ifdef INST_FETCH_ICACHE_EN
    n_total++; if (mem_req !== 1'b0) $display("FAIL pcfreeze_hit_req: got %b want 0", mem_req);          else n_pass++;
    n_total++; if (if_pc !== 32'hC)  $display("FAIL pcfreeze_hit_pc: got %h want %h", if_pc, 32'hC);     else n_pass++;
    n_total++; if (if_inst !== D3)   $display("FAIL pcfreeze_hit_inst: got %h want %h", if_inst, D3);    else n_pass++;
    tick();
`else
    n_total++; if (mem_addr !== 32'hC) $display("FAIL pcfreeze_refetch: got %h want %h", mem_addr, 32'hC); else n_pass++;
    mem_ready = 1'b1; mem_data = D3;
    tick();
    mem_ready = 1'b0;
    tick();
`endif
    n_total++; if (mem_addr !== 32'h10) $display("FAIL pcfreeze_next: got %h want %h", mem_addr, 32'h10); else n_pass++;
  endtask

  // Entered in BUSY(0x10).
  task automatic test_jump_busy();
    jump_en = 1'b1; jump_addr = 32'h100;
    tick();
    jump_en = 1'b0;
    n_total++; if (mem_req !== 1'b1)    $display("FAIL jb_discard_req: got %b want 1", mem_req);             else n_pass++;
    n_total++; if (mem_addr !== 32'h10) $display("FAIL jb_addr_stable: got %h want %h", mem_addr, 32'h10);   else n_pass++;
    n_total++; if (if_inst !== 32'h0)   $display("FAIL jb_bubble: got %h want %h", if_inst, 32'h0);          else n_pass++;
    mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    n_total++; if (if_inst !== 32'h0)  $display("FAIL jb_stale_ignored: got %h want %h", if_inst, 32'h0);  else n_pass++;
    n_total++; if (mem_req !== 1'b0)   $display("FAIL jb_idle_req: got %b want 0", mem_req);               else n_pass++;
    n_total++; if (stall_req !== 1'b1) $display("FAIL jb_idle_stall_req: got %b want 1", stall_req);       else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'h100) $display("FAIL jb_target: got %h want %h", mem_addr, 32'h100);    else n_pass++;
    mem_ready = 1'b1; mem_data = D4;
    tick();
    mem_ready = 1'b0;
    n_total++; if (if_pc !== 32'h100) $display("FAIL jb_if_pc: got %h want %h", if_pc, 32'h100); else n_pass++;
    n_total++; if (if_inst !== D4)    $display("FAIL jb_if_inst: got %h want %h", if_inst, D4);  else n_pass++;
    tick();
  endtask

  // Entered in BUSY(0x104): redirect and response in the same cycle.
  task automatic test_jump_ready();
    n_total++; if (mem_addr !== 32'h104) $display("FAIL jr_pre_addr: got %h want %h", mem_addr, 32'h104); else n_pass++;
    jump_en = 1'b1; jump_addr = 32'h200; mem_ready = 1'b1; mem_data = 32'h0BAD_0BAD;
    tick();
    jump_en = 1'b0;
    mem_data = 32'h0BAD_0002;  // ready left high while mem_req is low: must be ignored
    n_total++; if (mem_req !== 1'b0)   $display("FAIL jr_req: got %b want 0", mem_req);            else n_pass++;
    n_total++; if (if_inst !== 32'h0)  $display("FAIL jr_dropped: got %h want %h", if_inst, 32'h0); else n_pass++;
    n_total++; if (stall_req !== 1'b1) $display("FAIL jr_stall_req: got %b want 1", stall_req);    else n_pass++;
    tick();
    mem_ready = 1'b0;
    n_total++; if (mem_addr !== 32'h200) $display("FAIL jr_target: got %h want %h", mem_addr, 32'h200); else n_pass++;
    n_total++; if (if_inst !== 32'h0)    $display("FAIL jr_spurious: got %h want %h", if_inst, 32'h0);  else n_pass++;
    mem_ready = 1'b1; mem_data = D5;
    tick();
    mem_ready = 1'b0;
    n_total++; if (if_pc !== 32'h200) $display("FAIL jr_if_pc: got %h want %h", if_pc, 32'h200); else n_pass++;
  endtask

  // Entered in VALID(0x200): redirect suppresses the request, then PC wraps past the top.
  task automatic test_jump_valid_wrap();
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick();
    jump_en = 1'b0;
    n_total++; if (mem_req !== 1'b0)   $display("FAIL jv_suppressed: got %b want 0", mem_req);       else n_pass++;
    n_total++; if (if_inst !== 32'h0)  $display("FAIL jv_bubble: got %h want %h", if_inst, 32'h0);   else n_pass++;
    n_total++; if (stall_req !== 1'b1) $display("FAIL jv_stall_req: got %b want 1", stall_req);      else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want %h", mem_addr, 32'hFFFF_FFFC); else n_pass++;
    mem_ready = 1'b1; mem_data = D6;
    tick();
    mem_ready = 1'b0;
    n_total++; if (if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc: got %h want %h", if_pc, 32'hFFFF_FFFC); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'h0) $display("FAIL wrap_zero: got %h want %h", mem_addr, 32'h0); else n_pass++;
    n_total++; if (mem_req !== 1'b1)   $display("FAIL wrap_req: got %b want 1", mem_req);          else n_pass++;
  endtask

  // Entered in BUSY(0x0) with a request outstanding.
  task automatic test_reset_mid_fetch();
    rst = 1'b1;
    tick();
    n_total++; if (mem_req !== 1'b0)   $display("FAIL midrst_req: got %b want 0", mem_req);           else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL midrst_stall_req: got %b want 0", stall_req);   else n_pass++;
    n_total++; if (if_pc !== 32'h0)    $display("FAIL midrst_if_pc: got %h want %h", if_pc, 32'h0);   else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (mem_req !== 1'b1)   $display("FAIL midrst_restart: got %b want 1", mem_req);          else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL midrst_addr: got %h want %h", mem_addr, 32'h0);    else n_pass++;
    mem_ready = 1'b1; mem_data = D1;
    tick();
    mem_ready = 1'b0;
    n_total++; if (if_inst !== D1) $display("FAIL midrst_inst: got %h want %h", if_inst, D1); else n_pass++;
  endtask

`ifdef INST_FETCH_ICACHE_EN
  task automatic test_icache_loop();
    logic [31:0] addrs [3];
    logic [31:0] insts [3];
    addrs[0] = 32'h0; insts[0] = D0;
    addrs[1] = 32'h4; insts[1] = D1;
    addrs[2] = 32'h8; insts[2] = D2;
    rst = 1'b1; stall = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (mem_addr !== addrs[i]) $display("FAIL ic_fill_addr%0d: got %h want %h", i, mem_addr, addrs[i]); else n_pass++;
      mem_ready = 1'b1; mem_data = insts[i];
      tick();
      mem_ready = 1'b0;
    end
    tick();
    jump_en = 1'b1; jump_addr = 32'h0;
    tick();
    jump_en = 1'b0; mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (mem_req !== 1'b0)     $display("FAIL ic_hit_req%0d: got %b want 0", i, mem_req);               else n_pass++;
      n_total++; if (if_pc !== addrs[i])   $display("FAIL ic_hit_pc%0d: got %h want %h", i, if_pc, addrs[i]);       else n_pass++;
      n_total++; if (if_inst !== insts[i]) $display("FAIL ic_hit_inst%0d: got %h want %h", i, if_inst, insts[i]);   else n_pass++;
      n_total++; if (stall_req !== 1'b0)   $display("FAIL ic_hit_stall_req%0d: got %b want 0", i, stall_req);       else n_pass++;
    end
    tick();
    n_total++; if (mem_req !== 1'b1)   $display("FAIL ic_miss_req: got %b want 1", mem_req);            else n_pass++;
    n_total++; if (mem_addr !== 32'hC) $display("FAIL ic_miss_addr: got %h want %h", mem_addr, 32'hC); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_jump_busy();
    test_jump_ready();
    test_jump_valid_wrap();
    test_reset_mid_fetch();
`ifdef INST_FETCH_ICACHE_EN
    test_icache_loop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
